// File: rtl/tile_writeback.sv
// -----------------------------------------------------------------------------
// tile_writeback
//
// Copies a 32x32 byte tile from a tile buffer into a 256-column image memory.
// The tile's top-left corner lands at image (PASTE_ROW, PASTE_COL). The tile
// is read row-major. Each write follows its read by one cycle, because the
// tile buffer returns data one cycle after ce_src.
//
// Configuration macro:
//   TILE_WRITEBACK_MIRROR_EN - when defined, each tile row is mirrored
//                              horizontally. The destination column becomes
//                              PASTE_COL + (31 - col). Read order and timing
//                              are the same in both builds.
//
// Parameters:
//   PASTE_ROW  destination image row of the tile's top-left corner (<= 96)
//   PASTE_COL  destination image column of the tile's top-left corner (<= 224)
//
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   start     transfer request, sampled only in IDLE
//   busy      high while a transfer is in progress
//   done      one-cycle pulse at transfer completion
//   ce_src    tile buffer read enable
//   addr_src  tile buffer address, row*32+col
//   data_src  tile buffer read data, valid one cycle after ce_src
//   ce_dst    image memory chip enable
//   we_dst    image memory write enable
//   addr_dst  image address, (row+PASTE_ROW)*256 + destination column
//   data_dst  image write data, taken straight from data_src
// -----------------------------------------------------------------------------
module tile_writeback #(
    parameter int PASTE_ROW = 26,
    parameter int PASTE_COL = 122
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        ce_src,
    output logic [9:0]  addr_src,
    input  logic [7:0]  data_src,
    output logic        ce_dst,
    output logic        we_dst,
    output logic [14:0] addr_dst,
    output logic [7:0]  data_dst
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [9:0] LAST_INDEX = 10'd1023;

    state_t      state;
    // row/col hold the tile coordinate of the next read to issue.
    logic [4:0]  row;
    logic [4:0]  col;
    logic [4:0]  next_row;
    logic [4:0]  next_col;
    logic [4:0]  src_row;
    logic [4:0]  src_col;
    logic [4:0]  dst_col;
    logic [14:0] dst_addr;

    // Write data goes straight through. The buffer's read latency is already
    // matched by the one-cycle delay on the destination strobes.
    assign data_dst = data_src;

    always_comb begin
        // NOTE: every always_comb output gets a value on every path (defaults
        // first where needed) so that no latch is inferred.
        next_col = col + 5'd1;
        next_row = (col == 5'd31) ? row + 5'd1 : row;

        // The destination address comes from the address currently on the
        // read port. The registered copy then lines up with the returned data.
        src_row = addr_src[9:5];
        src_col = addr_src[4:0];
`ifdef TILE_WRITEBACK_MIRROR_EN
        dst_col = 5'd31 - src_col;
`else
        dst_col = src_col;
`endif
        // The legal parameter range keeps the full 15-bit result exact.
        dst_addr = (15'(src_row) + 15'(PASTE_ROW)) * 15'd256
                 + 15'(dst_col) + 15'(PASTE_COL);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // register then samples pre-edge values, whatever the statement order.
        if (rst) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ce_src   <= 1'b0;
            addr_src <= '0;
            ce_dst   <= 1'b0;
            we_dst   <= 1'b0;
            addr_dst <= '0;
        end else begin
            // Write stage: registered copy of the read stage. The address is
            // forced to zero when the write stage is idle.
            ce_dst   <= ce_src;
            we_dst   <= ce_src;
            addr_dst <= ce_src ? dst_addr : '0;
            done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= READ;
                        busy     <= 1'b1;
                        ce_src   <= 1'b1;
                        addr_src <= {row, col};
                        row      <= next_row;
                        col      <= next_col;
                    end
                end
                READ: begin
                    if (addr_src == LAST_INDEX) begin
                        // The last read is on the port this cycle. Stop reading.
                        // The counters have already wrapped back to (0,0).
                        state    <= DRAIN;
                        ce_src   <= 1'b0;
                        addr_src <= '0;
                    end else begin
                        addr_src <= {row, col};
                        row      <= next_row;
                        col      <= next_col;
                    end
                end
                DRAIN: begin
                    // The last write is on the port this cycle.
                    state <= FINISH;
                    done  <= 1'b1;
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_writeback.sv
// -----------------------------------------------------------------------------
// tb_tile_writeback
//
// Directed bench for tile_writeback. Two instances share start and rst:
//   dut   - default parameters (26, 122)
//   dut2  - corner parameters (96, 224), used to check the top address
// Each tile buffer is modelled as a one-cycle-latency ROM holding
// data = index mod 256. Expected image addresses come from a small
// reference function that follows TILE_WRITEBACK_MIRROR_EN.
// -----------------------------------------------------------------------------
module tb_tile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;

    logic        busy, done, ce_src, ce_dst, we_dst;
    logic [9:0]  addr_src;
    logic [7:0]  data_src, data_dst;
    logic [14:0] addr_dst;

    logic        busy2, done2, ce_src2, ce_dst2, we_dst2;
    logic [9:0]  addr_src2;
    logic [7:0]  data_src2, data_dst2;
    logic [14:0] addr_dst2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tile_writeback dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ce_src(ce_src), .addr_src(addr_src), .data_src(data_src),
        .ce_dst(ce_dst), .we_dst(we_dst), .addr_dst(addr_dst), .data_dst(data_dst)
    );

    tile_writeback #(.PASTE_ROW(96), .PASTE_COL(224)) dut2 (
        .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2),
        .ce_src(ce_src2), .addr_src(addr_src2), .data_src(data_src2),
        .ce_dst(ce_dst2), .we_dst(we_dst2), .addr_dst(addr_dst2), .data_dst(data_dst2)
    );

    // Tile buffer ROMs: data = index mod 256, returned one cycle after ce.
    always @(posedge clk) begin
        if (ce_src)  data_src  <= addr_src[7:0];
        if (ce_src2) data_src2 <= addr_src2[7:0];
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_dst(input int r, input int c, input int pr, input int pc);
        int cc;
        cc = c;
`ifdef TILE_WRITEBACK_MIRROR_EN
        cc = 31 - c;
`endif
        return (r + pr) * 256 + pc + cc;
    endfunction

    // Statistics collected by run().
    int first_ce, last_ce, second_ce, first_we, last_we, we_cnt;
    int first_addr, first_data, last_addr, last_data, addr31, last_addr2;
    int busy_first, busy_last, busy_cnt, done_cnt, done_cyc;
    int order_err, data_err, zero_err, rd_idx, wr_idx, we_after_rst, post_rst;

    // Runs one stimulus scenario. The edge that samples start is edge 0, and
    // cycle k is sampled on the falling edge that follows edge k-1.
    //   hold     keep start high until the done cycle
    //   chain    raise start again in the cycle after done
    //   abort_at raise rst during that cycle (0 = no abort)
    task automatic run(input bit hold, input bit chain, input int ncyc, input int abort_at);
        first_ce = 0; last_ce = 0; second_ce = 0; first_we = 0; last_we = 0;
        we_cnt = 0; first_addr = -1; first_data = -1; last_addr = -1;
        last_data = -1; addr31 = -1; last_addr2 = -1; busy_first = 0;
        busy_last = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0;
        order_err = 0; data_err = 0; zero_err = 0; rd_idx = 0; wr_idx = 0;
        we_after_rst = 0; post_rst = -1;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (ce_src) begin
                if (first_ce == 0) first_ce = k;
                if (done_cnt > 0 && second_ce == 0) second_ce = k;
                last_ce = k;
                if (int'(addr_src) != rd_idx % 1024) order_err++;
                rd_idx++;
            end else if (addr_src != 10'd0) begin
                zero_err++;
            end
            if (!ce_dst && (addr_dst != 15'd0 || we_dst)) zero_err++;
            if (we_dst) begin
                if (first_we == 0) begin
                    first_we   = k;
                    first_addr = int'(addr_dst);
                    first_data = int'(data_dst);
                end
                last_we   = k;
                last_addr = int'(addr_dst);
                last_data = int'(data_dst);
                if (wr_idx % 1024 == 31) addr31 = int'(addr_dst);
                if (int'(data_dst) != wr_idx % 256) data_err++;
                wr_idx++;
                we_cnt++;
                if (abort_at != 0 && k > abort_at) we_after_rst++;
            end
            if (we_dst2) last_addr2 = int'(addr_dst2);
            if (busy) begin
                if (busy_first == 0) busy_first = k;
                busy_last = k;
                busy_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (abort_at != 0 && k == abort_at + 1) begin
                post_rst = int'(busy) + int'(done) + int'(ce_src) + int'(ce_dst)
                         + int'(we_dst) + int'(addr_src) + int'(addr_dst);
                rst = 1'b0;
            end

            // Drive the inputs for the rest of this cycle.
            if (!hold || k >= 1026) start = 1'b0;
            if (chain && k == 1027) start = 1'b1;
            if (abort_at != 0 && k == abort_at) rst = 1'b1;
        end
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;    // rst must win over start
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'(busy) + int'(done) + int'(ce_src) + int'(ce_dst)
              + int'(we_dst) + int'(addr_src) + int'(addr_dst), 0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Single transfer with a start pulse.
        run(1'b0, 1'b0, 1100, 0);
        check("first_ce", first_ce, 1);
        check("last_ce", last_ce, 1024);
        check("first_we", first_we, 2);
        check("last_we", last_we, 1025);
        check("we_count", we_cnt, 1024);
        check("first_addr", first_addr, exp_dst(0, 0, 26, 122));
        check("first_data", first_data, 0);
        check("last_addr", last_addr, exp_dst(31, 31, 26, 122));
        check("last_data", last_data, 255);
        check("tile_0_31_addr", addr31, exp_dst(0, 31, 26, 122));
        check("read_order", order_err, 0);
        check("write_data", data_err, 0);
        check("idle_addr_zero", zero_err, 0);
        check("done_count", done_cnt, 1);
        check("done_cycle", done_cyc, 1026);
        check("busy_first", busy_first, 1);
        check("busy_last", busy_last, 1026);
        check("busy_count", busy_cnt, 1026);
        check("corner_last_addr", last_addr2, 32767);
        repeat (3) @(negedge clk);

        // start held high for the whole transfer.
        run(1'b1, 1'b0, 1100, 0);
        check("hold_we_count", we_cnt, 1024);
        check("hold_done_count", done_cnt, 1);
        check("hold_busy_first", busy_first, 1);
        check("hold_busy_count", busy_cnt, 1026);
        check("hold_busy_last", busy_last, 1026);
        repeat (3) @(negedge clk);

        // Reset during cycle 500 aborts the transfer.
        run(1'b0, 1'b0, 1100, 500);
        check("abort_outputs_zero", post_rst, 0);
        check("abort_done_count", done_cnt, 0);
        check("abort_writes_after", we_after_rst, 0);
        check("abort_idle_addr_zero", zero_err, 0);
        repeat (3) @(negedge clk);

        // A fresh transfer after the abort starts at the top-left again.
        run(1'b0, 1'b0, 1100, 0);
        check("restart_first_addr", first_addr, exp_dst(0, 0, 26, 122));
        check("restart_first_data", first_data, 0);
        check("restart_we_count", we_cnt, 1024);
        repeat (3) @(negedge clk);

        // Back-to-back: start in the cycle after done.
        run(1'b0, 1'b1, 2200, 0);
        check("chain_second_ce", second_ce, 1028);
        check("chain_we_count", we_cnt, 2048);
        check("chain_done_count", done_cnt, 2);
        check("chain_last_we", last_we, 1025 + 1027);
        check("chain_read_order", order_err, 0);
        check("chain_write_data", data_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_writeback.md
TILE_WRITEBACK -- requirements
Module: tile_writeback

Interface
REQ-001 The module SHALL have parameter PASTE_ROW, default 26, giving the destination image row of the tile's top-left corner.
REQ-002 The module SHALL have parameter PASTE_COL, default 122, giving the destination image column of the tile's top-left corner.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-005 start  input  1  is the transfer request, sampled only in IDLE.
REQ-006 busy  output  1  SHALL be high while a transfer is in progress.
REQ-007 done  output  1  SHALL be a one-cycle pulse at transfer completion.
REQ-008 ce_src  output  1  is the read enable of the 32x32 tile buffer.
REQ-009 addr_src  output  10  is the tile buffer address: row*32+col.
REQ-010 data_src  input  8  is tile buffer read data, valid one cycle after ce_src.
REQ-011 ce_dst  output  1  is the chip enable of the 256-column image memory.
REQ-012 we_dst  output  1  is the write enable of the image memory.
REQ-013 addr_dst  output  15  is the image address: (row+PASTE_ROW)*256+(col+PASTE_COL).
REQ-014 data_dst  output  8  is the image write data.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, READ, DRAIN and FINISH.
REQ-016 State transitions SHALL be:
- IDLE -> READ on start=1.
- READ -> DRAIN after the read of tile index 1023.
- DRAIN -> FINISH after one cycle.
- FINISH -> IDLE after one cycle.
REQ-017 In READ, ce_src SHALL be 1 for exactly 1024 consecutive cycles, scanning row-major with col incrementing fastest from (0,0) to (31,31).
REQ-018 ce_dst, we_dst and addr_dst SHALL be registered copies of the READ-stage strobe and coordinates, delayed one cycle.
- Writes therefore occur one cycle after the matching read.
- Writes SHALL be high for exactly 1024 consecutive cycles.
REQ-019 data_dst SHALL equal data_src combinationally.
REQ-020 Timing from the edge that samples start in IDLE (edge 0):
- First ce_src at cycle 1; last ce_src at cycle 1024.
- First we_dst at cycle 2; last we_dst at cycle 1025.
- done=1 at cycle 1026.
REQ-021 busy SHALL be 1 from cycle 1 through cycle 1026 inclusive, and 0 otherwise.
REQ-022 start SHALL be ignored whenever the FSM is not in IDLE.
REQ-023 A start in the cycle after done SHALL begin a new transfer with no extra gap.
REQ-024 When ce_src is 0, addr_src SHALL be 0.
REQ-025 When ce_dst is 0, addr_dst SHALL be 0 and we_dst SHALL be 0.
REQ-026 Tile row and column counters SHALL be 5 bits each and wrap from 31 to 0.
REQ-027 The row counter SHALL increment when col wraps from 31 to 0.
REQ-028 Destination address arithmetic SHALL be computed at 15 bits with no truncation.
- Parameters SHALL satisfy PASTE_ROW<=96 and PASTE_COL<=224.
- Behaviour outside these limits is undefined.

Reset
REQ-029 On rst=1 the state SHALL go to IDLE, counters to 0, and busy, done, ce_src, ce_dst, we_dst, addr_src and addr_dst to 0, at the next rising clk edge.
REQ-030 A reset asserted mid-transfer SHALL abort the transfer immediately.
- No further we_dst pulses after the reset edge.
- No done pulse for the aborted transfer.
REQ-031 rst SHALL take priority over start in the same cycle.

Configuration
REQ-032 Macro TILE_WRITEBACK_MIRROR_EN SHALL compile in horizontal mirroring.
- When defined, the destination column SHALL be PASTE_COL+(31-col).
- When undefined, the destination column SHALL be PASTE_COL+col.
- Read order, timing, busy/done and addr_src SHALL be identical in both builds.

Verification
REQ-033 Tile buffer preloaded with data=index (mod 256), defaults, start pulse -> first write addr_dst=6778 with data 0; last write addr_dst=14745 with data 255 (1023 mod 256); exactly 1024 writes; done at cycle 1026.
REQ-034 start held high for the whole transfer -> exactly one transfer, one done pulse, busy continuous cycles 1-1026.
REQ-035 rst=1 at cycle 500 -> all outputs 0 after that edge, no done pulse; a new start then gives first write at addr_dst=6778.
REQ-036 start asserted in the cycle after done -> second transfer's first ce_src one cycle later; 2048 writes total.
REQ-037 TILE_WRITEBACK_MIRROR_EN defined, defaults -> first write addr_dst=6809 with data 0; write for tile (0,31) at addr_dst=6778.
REQ-038 PASTE_ROW=96, PASTE_COL=224 -> last write addr_dst=32767, no wrap to low addresses.
